// File: rtl/recepcion.sv
// recepcion: 8N1 UART receiver for the HC-05 Bluetooth link.
// Derives a bit-rate clock (clk_div) from clk_in, samples the synchronized
// serial line once per bit on the falling edge of clk_div, and presents each
// correctly framed byte on dout with a one-bit-period rcv pulse.
module recepcion #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx,
    output logic       clk_div,
    output logic [7:0] dout,
    output logic       rcv
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    // Power-up values equal the reset values so the block works with reset tied low.
    logic [CW-1:0] cnt_q     = '0;
    logic          clk_div_q = 1'b0;
    logic [1:0]    sync_q    = 2'b11;
    state_t        state_q   = IDLE;
    logic [2:0]    idx_q     = 3'd0;
    logic [7:0]    shift_q   = 8'h00;
    logic [7:0]    dout_q    = 8'h00;
    logic          rcv_q     = 1'b0;

    state_t        state_d;
    logic [2:0]    idx_d;
    logic [7:0]    shift_d;
    logic [7:0]    dout_d;
    logic          rcv_d;

    logic          strobe;
    logic          rx_s;

    // The strobe coincides with the falling edge of clk_div: mid-bit for data
    // launched on its rising edge.
    assign strobe = (cnt_q == CNT_LAST);
    assign rx_s   = sync_q[1];

    // Bit-rate divider: clk_div rises at mid-count, falls when the count wraps.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
        end else if (strobe) begin
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_HALF) begin
                clk_div_q <= 1'b1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous serial line (idle level 1).
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Frame FSM next state; everything advances only on a sample strobe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        rcv_d   = rcv_q;
        if (strobe) begin
            rcv_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end
                end
                DATA: begin
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                STOP: begin
                    // A low stop bit is a framing error: the byte is dropped.
                    state_d = IDLE;
                    if (rx_s) begin
                        dout_d = shift_q;
                        rcv_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            dout_q  <= 8'h00;
            rcv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            rcv_q   <= rcv_d;
        end
    end

    assign clk_div = clk_div_q;
    assign dout    = dout_q;
    assign rcv     = rcv_q;

endmodule

// File: tb/tb_recepcion.sv
// tb_recepcion: directed and randomized frames against a byte-level model of
// the 8N1 receiver, on two instances with different bit-rate divisors.
module tb_recepcion;

    localparam int BD  = 20;
    localparam int BD8 = 8;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       rx     = 1'b1;
    logic       clk_div;
    logic [7:0] dout;
    logic       rcv;

    logic       reset8 = 1'b0;
    logic       rx8    = 1'b1;
    logic       clk_div8;
    logic [7:0] dout8;
    logic       rcv8;

    always #5 clk_in = ~clk_in;

    recepcion #(.BAUD_DIV(BD)) u_dut (
        .clk_in (clk_in),
        .reset  (reset),
        .rx     (rx),
        .clk_div(clk_div),
        .dout   (dout),
        .rcv    (rcv)
    );

    recepcion #(.BAUD_DIV(BD8)) u_dut8 (
        .clk_in (clk_in),
        .reset  (reset8),
        .rx     (rx8),
        .clk_div(clk_div8),
        .dout   (dout8),
        .rcv    (rcv8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // cyc = number of rising clk_in edges so far; read at falling edges.
    int cyc = 0;
    always @(posedge clk_in) cyc++;

    // Receive monitor for the main instance.
    logic [7:0] got_q[$];
    int         len_q[$];
    int         rise_cyc = -1;
    logic       rcv_prev = 1'b0;
    always @(negedge clk_in) begin
        if (rcv && !rcv_prev) begin
            got_q.push_back(dout);
            rise_cyc = cyc;
        end
        if (!rcv && rcv_prev) len_q.push_back(cyc - rise_cyc);
        rcv_prev = rcv;
    end

    // Receive monitor for the BAUD_DIV = 8 instance.
    int         n_rcv8    = 0;
    logic [7:0] got8      = 8'h00;
    int         rise8     = 0;
    int         len8      = -1;
    logic       rcv8_prev = 1'b0;
    always @(negedge clk_in) begin
        if (rcv8 && !rcv8_prev) begin
            n_rcv8++;
            got8  = dout8;
            rise8 = cyc;
        end
        if (!rcv8 && rcv8_prev) len8 = cyc - rise8;
        rcv8_prev = rcv8;
    end

    // Reference model: a frame yields its byte iff its stop bit is 1.
    logic [7:0] exp_q[$];
    logic [7:0] exp_dout = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next rising edge of the selected clk_div.
    task automatic wait_rise(input bit w8);
        logic prev, cur;
        bit   seen;
        seen = 1'b0;
        prev = w8 ? clk_div8 : clk_div;
        for (int i = 0; i < 2 * BD + 4 && !seen; i++) begin
            @(negedge clk_in);
            cur = w8 ? clk_div8 : clk_div;
            if (cur && !prev) seen = 1'b1;
            prev = cur;
        end
        if (!seen) check("clk_div_timeout", 32'(seen), 32'd1);
    endtask

    task automatic drive_bit(input bit w8, input logic b);
        wait_rise(w8);
        if (w8) rx8 = b;
        else    rx  = b;
    endtask

    task automatic send_frame(input bit w8, input logic [7:0] data, input logic stopb);
        drive_bit(w8, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(w8, data[i]);
        drive_bit(w8, stopb);
        if (!w8 && stopb) begin
            exp_q.push_back(data);
            exp_dout = data;
        end
    endtask

    task automatic idle_bits(input bit w8, input int n);
        for (int i = 0; i < n; i++) drive_bit(w8, 1'b1);
    endtask

    // Compare everything received against the model, then drain both.
    task automatic check_queue(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        for (int i = 0; i < len_q.size(); i++)
            check({tag, "_rcv_len"}, 32'(len_q[i]), 32'(BD));
        check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        got_q.delete();
        exp_q.delete();
        len_q.delete();
    endtask

    initial begin
        int         n_rise1, n_fall, n_rise2, k, t_start;
        logic       prev;
        logic [7:0] d;
        logic       sb;

        // Power-up with reset never asserted.
        @(negedge clk_in);
        check("pwr_clk_div", 32'(clk_div), 32'd0);
        check("pwr_dout", 32'(dout), 32'd0);
        check("pwr_rcv", 32'(rcv), 32'd0);
        n_rise1 = -1; n_fall = -1; n_rise2 = -1;
        prev = clk_div;
        for (int i = 0; i < 3 * BD && n_rise2 < 0; i++) begin
            if (i > 0) @(negedge clk_in);
            if (clk_div && !prev) begin
                if (n_rise1 < 0) n_rise1 = cyc;
                else n_rise2 = cyc;
            end
            if (!clk_div && prev && n_fall < 0) n_fall = cyc;
            prev = clk_div;
        end
        check("pwr_first_rise", 32'(n_rise1), 32'(BD / 2));
        check("pwr_first_fall", 32'(n_fall), 32'(BD));
        check("pwr_period", 32'(n_rise2 - n_rise1), 32'(BD));

        // Single frame 0xAA with latency and pulse-width checks.
        idle_bits(1'b0, 3);
        drive_bit(1'b0, 1'b0);
        t_start = cyc;
        for (int i = 0; i < 8; i++) drive_bit(1'b0, (i % 2) == 1);
        drive_bit(1'b0, 1'b1);
        exp_q.push_back(8'hAA);
        exp_dout = 8'hAA;
        idle_bits(1'b0, 2);
        check("aa_latency", 32'(rise_cyc), 32'(t_start + BD / 2 + 9 * BD));
        check_queue("aa");

        // Back-to-back frames with a single stop bit.
        send_frame(1'b0, 8'h01, 1'b1);
        send_frame(1'b0, 8'hC3, 1'b1);
        idle_bits(1'b0, 2);
        check_queue("b2b");

        // Framing error, then a good frame.
        send_frame(1'b0, 8'h5A, 1'b0);
        idle_bits(1'b0, 1);
        check("ferr_dout_held", 32'(dout), 32'hC3);
        send_frame(1'b0, 8'h3C, 1'b1);
        idle_bits(1'b0, 2);
        check_queue("ferr");

        // Reset pulse during data bit 4 aborts the frame and restarts the divider.
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b1);
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        rx = 1'b1;
        exp_dout = 8'h00;
        check("rst_clk_div", 32'(clk_div), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rcv", 32'(rcv), 32'd0);
        k = 0;
        for (int i = 1; i <= 2 * BD && k == 0; i++) begin
            @(negedge clk_in);
            if (clk_div) k = i;
        end
        check("rst_div_restart", 32'(k), 32'(BD / 2));
        idle_bits(1'b0, 2);
        check_queue("rst_abort");
        send_frame(1'b0, 8'h7E, 1'b1);
        idle_bits(1'b0, 2);
        check_queue("rst_7e");

        // Randomized frames: random data, occasional bad stop bit, random gaps.
        for (int f = 0; f < 12; f++) begin
            d  = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 4) != 0);
            send_frame(1'b0, d, sb);
            idle_bits(1'b0, int'($urandom_range(0, 2)));
        end
        idle_bits(1'b0, 2);
        check_queue("rand");

        // Second instance with BAUD_DIV = 8.
        idle_bits(1'b1, 3);
        send_frame(1'b1, 8'hAA, 1'b1);
        idle_bits(1'b1, 2);
        check("bd8_count", 32'(n_rcv8), 32'd1);
        check("bd8_byte", 32'(got8), 32'hAA);
        check("bd8_rcv_len", 32'(len8), 32'(BD8));
        check("bd8_dout", 32'(dout8), 32'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
